// File: rtl/rgb2ycbcr_pipe_if.sv
// rgb2ycbcr_pipe_if: pixel stream bus around the RGB->YCbCr converter.
//   per_frame_vsync/href/clken, per_img_red/green/blue : RGB input stream
//   post_frame_vsync/href/clken                        : syncs delayed to match output data
//   post_img_Y/Cb/Cr, post_c_is_cr                     : YCbCr output stream
// master drives the RGB stream and reads the YCbCr stream; slave is the converter.
interface rgb2ycbcr_pipe_if #(parameter int DW = 8);
    logic          per_frame_vsync;
    logic          per_frame_href;
    logic          per_frame_clken;
    logic [DW-1:0] per_img_red;
    logic [DW-1:0] per_img_green;
    logic [DW-1:0] per_img_blue;
    logic          post_frame_vsync;
    logic          post_frame_href;
    logic          post_frame_clken;
    logic [DW-1:0] post_img_Y;
    logic [DW-1:0] post_img_Cb;
    logic [DW-1:0] post_img_Cr;
    logic          post_c_is_cr;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
               per_img_red, per_img_green, per_img_blue,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
               post_img_Y, post_img_Cb, post_img_Cr, post_c_is_cr
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
               per_img_red, per_img_green, per_img_blue,
        output post_frame_vsync, post_frame_href, post_frame_clken,
               post_img_Y, post_img_Cb, post_img_Cr, post_c_is_cr
    );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 4-stage RGB->YCbCr converter with selectable standard, rounding,
// saturation and optional co-sited 4:2:2 chroma.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   cfg_std    : 00 BT.601 full, 01 BT.601 limited, 10 BT.709 limited (11 = 00)
//   cfg_422    : 1 = 4:2:2 chroma on post_img_Cb, 0 = 4:4:4
//   bus        : pixel stream (slave side), outputs LAT = 4 cycles after inputs
module rgb2ycbcr_pipe #(
    parameter int DW = 8,
    parameter int CW = 10
) (
    input logic            clk,
    input logic            rst_n,
    input logic [1:0]      cfg_std,
    input logic            cfg_422,
    rgb2ycbcr_pipe_if.slave bus
);
    localparam int KW = CW + 2;
    localparam int PW = DW + CW + 3;
    localparam int SW = PW + 1;

    // Coefficients are given in millionths; round half away from zero to CW bits.
    function automatic int kq(input int cm);
        longint a, q;
        a = longint'(cm < 0 ? -cm : cm) << CW;
        q = (a + 64'sd500000) / 64'sd1000000;
        return cm < 0 ? int'(-q) : int'(q);
    endfunction

    // Rows Y/Cb/Cr, columns R/G/B; three blocks of nine for 601 full, 601 limited, 709 limited.
    localparam int K [27] = '{
        kq(299000), kq(587000), kq(114000),
        kq(-168736), kq(-331264), kq(500000),
        kq(500000), kq(-418688), kq(-81312),
        kq(256788), kq(504129), kq(97906),
        kq(-148223), kq(-290993), kq(439216),
        kq(439216), kq(-367788), kq(-71427),
        kq(182586), kq(614231), kq(62007),
        kq(-100644), kq(-338572), kq(439216),
        kq(439216), kq(-398942), kq(-40274)
    };

    localparam logic signed [SW-1:0] OY   = SW'((16 << (DW - 8)) << CW);
    localparam logic signed [SW-1:0] OC   = SW'((128 << (DW - 8)) << CW);
    localparam logic signed [SW-1:0] RND  = SW'(1 << (CW - 1));
    localparam logic signed [SW-1:0] VMAX = SW'((1 << DW) - 1);

    function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = v >>> CW;
        return t[SW-1] ? '0 : (t > VMAX) ? '1 : t[DW-1:0];
    endfunction

    logic                 vs_d;
    logic [1:0]           std_q;
    logic                 c422_q;
    logic [3:0]           vs_sr, hr_sr, ce_sr;
    logic [DW-1:0]        px [3];
    logic signed [KW-1:0] k [9];
    logic signed [PW-1:0] p [9];
    logic                 lim1;
    logic [2:0]           m422;
    logic signed [SW-1:0] s [3];
    logic [DW-1:0]        c3 [3];
    logic                 ph;
    logic [DW-1:0]        cr_hold;
    logic [DW-1:0]        y_o, cb_o, cr_o;
    logic                 cis_o;

    always_comb begin
        px[0] = bus.per_img_red;
        px[1] = bus.per_img_green;
        px[2] = bus.per_img_blue;
        for (int i = 0; i < 9; i++)
            k[i] = KW'(std_q == 2'd1 ? K[9 + i] : std_q == 2'd2 ? K[18 + i] : K[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d    <= 1'b0;
            std_q   <= 2'd0;
            c422_q  <= 1'b0;
            vs_sr   <= '0;
            hr_sr   <= '0;
            ce_sr   <= '0;
            lim1    <= 1'b0;
            m422    <= '0;
            ph      <= 1'b0;
            cr_hold <= '0;
            y_o     <= '0;
            cb_o    <= '0;
            cr_o    <= '0;
            cis_o   <= 1'b0;
            for (int i = 0; i < 9; i++) p[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                s[i]  <= '0;
                c3[i] <= '0;
            end
        end else begin
            vs_d <= bus.per_frame_vsync;
            if (bus.per_frame_vsync && !vs_d) begin
                std_q  <= cfg_std;
                c422_q <= cfg_422;
            end
            vs_sr <= {vs_sr[2:0], bus.per_frame_vsync};
            hr_sr <= {hr_sr[2:0], bus.per_frame_href};
            ce_sr <= {ce_sr[2:0], bus.per_frame_clken};
            // S1: products; config travels with the pixel so a vsync change never splits one
            for (int i = 0; i < 9; i++)
                p[i] <= PW'($signed({1'b0, px[i % 3]})) * PW'(k[i]);
            lim1 <= std_q == 2'd1 || std_q == 2'd2;
            m422 <= {m422[1:0], c422_q};
            // S2: sums with offset and rounding
            s[0] <= SW'(p[0]) + SW'(p[1]) + SW'(p[2]) + (lim1 ? OY : SW'(0)) + RND;
            s[1] <= SW'(p[3]) + SW'(p[4]) + SW'(p[5]) + OC + RND;
            s[2] <= SW'(p[6]) + SW'(p[7]) + SW'(p[8]) + OC + RND;
            // S3: scale back and saturate
            for (int i = 0; i < 3; i++) c3[i] <= clamp(s[i]);
            // S4: chroma phase counts only qualified pixels and restarts every line
            ph <= hr_sr[2] && (ce_sr[2] ? !ph : ph);
            if (hr_sr[2] && ce_sr[2] && !ph) cr_hold <= c3[2];
            y_o   <= hr_sr[2] ? c3[0] : '0;
            cb_o  <= !hr_sr[2] ? '0 : (m422[2] && ph) ? cr_hold : c3[1];
            cr_o  <= (hr_sr[2] && !m422[2]) ? c3[2] : '0;
            cis_o <= hr_sr[2] && m422[2] && ph;
        end
    end

    assign bus.post_frame_vsync = vs_sr[3];
    assign bus.post_frame_href  = hr_sr[3];
    assign bus.post_frame_clken = ce_sr[3];
    assign bus.post_img_Y       = y_o;
    assign bus.post_img_Cb      = cb_o;
    assign bus.post_img_Cr      = cr_o;
    assign bus.post_c_is_cr     = cis_o;
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// tb_rgb2ycbcr_pipe: directed bench for rgb2ycbcr_pipe (DW=8, CW=10).
module tb_rgb2ycbcr_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cfg_std = 2'd0;
    logic       cfg_422 = 1'b0;

    always #5 clk = ~clk;

    rgb2ycbcr_pipe_if #(.DW(8)) bus ();

    rgb2ycbcr_pipe #(.DW(8), .CW(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_std(cfg_std),
        .cfg_422(cfg_422),
        .bus(bus)
    );

    int n = 0, pass_n = 0, fail_n = 0, total_n = 0;
    int t, t2;
    logic       in_vs [512], in_hr [512], in_ce [512];
    logic       o_vs [512], o_hr [512], o_ce [512], o_cis [512];
    logic [7:0] o_y [512], o_cb [512], o_cr [512];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        assert (got === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of input, then log outputs 1 time unit after the edge.
    // Input logged at index i shows up at output index i+3.
    task automatic tick(input logic vs, input logic hr, input logic ce,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.per_frame_vsync = vs;
        bus.per_frame_href  = hr;
        bus.per_frame_clken = ce;
        bus.per_img_red     = r;
        bus.per_img_green   = g;
        bus.per_img_blue    = b;
        in_vs[n] = vs;
        in_hr[n] = hr;
        in_ce[n] = ce;
        @(posedge clk);
        #1;
        o_vs[n]  = bus.post_frame_vsync;
        o_hr[n]  = bus.post_frame_href;
        o_ce[n]  = bus.post_frame_clken;
        o_y[n]   = bus.post_img_Y;
        o_cb[n]  = bus.post_img_Cb;
        o_cr[n]  = bus.post_img_Cr;
        o_cis[n] = bus.post_c_is_cr;
        n++;
    endtask

    task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        tick(1'b0, 1'b1, 1'b1, r, g, b);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic chk_px(input string tag, input int ti, input int y, input int cb,
                          input int cr, input int cis);
        chk($sformatf("%s_hr", tag), 32'(o_hr[ti + 3]), 1);
        chk($sformatf("%s_y", tag), 32'(o_y[ti + 3]), y);
        chk($sformatf("%s_cb", tag), 32'(o_cb[ti + 3]), cb);
        chk($sformatf("%s_cr", tag), 32'(o_cr[ti + 3]), cr);
        chk($sformatf("%s_cis", tag), 32'(o_cis[ti + 3]), cis);
    endtask

    initial begin
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        bus.per_img_red     = 8'd0;
        bus.per_img_green   = 8'd0;
        bus.per_img_blue    = 8'd0;
        // Reset held with active inputs: everything stays 0
        repeat (5) tick(1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
        chk("rst_vs", 32'(o_vs[n - 1]), 0);
        chk("rst_hr", 32'(o_hr[n - 1]), 0);
        chk("rst_ce", 32'(o_ce[n - 1]), 0);
        chk("rst_y", 32'(o_y[n - 1]), 0);
        chk("rst_cb", 32'(o_cb[n - 1]), 0);
        chk("rst_cr", 32'(o_cr[n - 1]), 0);
        chk("rst_cis", 32'(o_cis[n - 1]), 0);
        rst_n = 1'b1;
        repeat (2) idle();
        // BT.601 full (default after reset), 4:4:4
        t = n;
        px(8'd0, 8'd0, 8'd0);
        px(8'd255, 8'd255, 8'd255);
        px(8'd255, 8'd0, 8'd0);
        px(8'd0, 8'd255, 8'd0);
        px(8'd0, 8'd0, 8'd255);
        repeat (4) idle();
        chk_px("f_black", t, 0, 128, 128, 0);
        chk_px("f_white", t + 1, 255, 128, 128, 0);
        chk_px("f_red", t + 2, 76, 85, 255, 0);
        chk_px("f_green", t + 3, 150, 44, 21, 0);
        chk_px("f_blue", t + 4, 29, 255, 107, 0);
        chk("gate_hr", 32'(o_hr[t + 8]), 0);
        chk("gate_y", 32'(o_y[t + 8]), 0);
        chk("gate_cb", 32'(o_cb[t + 8]), 0);
        chk("gate_cr", 32'(o_cr[t + 8]), 0);
        // BT.601 limited latched at vsync rise; mid-frame change to 709 ignored
        cfg_std = 2'd1;
        tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        cfg_std = 2'd2;
        idle();
        t = n;
        px(8'd255, 8'd255, 8'd255);
        px(8'd0, 8'd0, 8'd0);
        px(8'd255, 8'd0, 8'd0);
        repeat (4) idle();
        chk_px("l_white", t, 235, 128, 128, 0);
        chk_px("l_black", t + 1, 16, 128, 128, 0);
        chk_px("l_red", t + 2, 81, 90, 240, 0);
        // Next vsync rise picks up BT.709 limited
        tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        idle();
        t = n;
        px(8'd255, 8'd0, 8'd0);
        repeat (4) idle();
        chk_px("h_red", t, 63, 102, 240, 0);
        // 4:2:2, BT.601 full: 5-pixel line with a clken gap, then a 2-pixel line
        cfg_std = 2'd0;
        cfg_422 = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        idle();
        t = n;
        px(8'd255, 8'd0, 8'd0);
        tick(1'b0, 1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
        px(8'd0, 8'd255, 8'd0);
        px(8'd0, 8'd0, 8'd255);
        px(8'd255, 8'd255, 8'd255);
        px(8'd0, 8'd0, 8'd0);
        repeat (2) idle();
        t2 = n;
        px(8'd0, 8'd255, 8'd0);
        px(8'd255, 8'd0, 8'd0);
        repeat (4) idle();
        chk_px("c_p0", t, 76, 85, 0, 0);
        chk_px("c_gap", t + 1, 255, 255, 0, 1);
        chk_px("c_p1", t + 2, 150, 255, 0, 1);
        chk_px("c_p2", t + 3, 29, 255, 0, 0);
        chk_px("c_p3", t + 4, 255, 107, 0, 1);
        chk_px("c_p4", t + 5, 0, 128, 0, 0);
        chk("c_gate_cb", 32'(o_cb[t + 9]), 0);
        chk("c_gate_cis", 32'(o_cis[t + 9]), 0);
        chk_px("c_n0", t2, 150, 44, 0, 0);
        chk_px("c_n1", t2 + 1, 76, 21, 0, 1);
        // Random syncs: exact 4-cycle delay and gating while href is low
        cfg_422 = 1'b0;
        t = n;
        for (int i = 0; i < 40; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom), 8'($urandom));
        repeat (3) idle();
        for (int i = t + 3; i < t + 43; i++) begin
            chk($sformatf("sync_vs[%0d]", i), 32'(o_vs[i]), 32'(in_vs[i - 3]));
            chk($sformatf("sync_hr[%0d]", i), 32'(o_hr[i]), 32'(in_hr[i - 3]));
            chk($sformatf("sync_ce[%0d]", i), 32'(o_ce[i]), 32'(in_ce[i - 3]));
            if (!in_hr[i - 3]) begin
                chk($sformatf("rgate_y[%0d]", i), 32'(o_y[i]), 0);
                chk($sformatf("rgate_cb[%0d]", i), 32'(o_cb[i]), 0);
                chk($sformatf("rgate_cr[%0d]", i), 32'(o_cr[i]), 0);
                chk($sformatf("rgate_cis[%0d]", i), 32'(o_cis[i]), 0);
            end
        end
        // Mid-line asynchronous reset with BT.601 limited 4:2:2 latched
        idle();
        cfg_std = 2'd1;
        cfg_422 = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        idle();
        repeat (5) px(8'd255, 8'd255, 8'd255);
        chk("pre_rst_y", 32'(o_y[n - 1]), 235);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_y", 32'(bus.post_img_Y), 0);
        chk("arst_cb", 32'(bus.post_img_Cb), 0);
        chk("arst_cr", 32'(bus.post_img_Cr), 0);
        chk("arst_hr", 32'(bus.post_frame_href), 0);
        chk("arst_ce", 32'(bus.post_frame_clken), 0);
        chk("arst_vs", 32'(bus.post_frame_vsync), 0);
        chk("arst_cis", 32'(bus.post_c_is_cr), 0);
        repeat (2) px(8'd255, 8'd255, 8'd255);
        rst_n = 1'b1;
        repeat (2) idle();
        t = n;
        repeat (3) px(8'd255, 8'd255, 8'd255);
        repeat (4) idle();
        chk("refill_hr", 32'(o_hr[t + 2]), 0);
        chk("refill_y", 32'(o_y[t + 2]), 0);
        chk_px("refill", t, 255, 128, 128, 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
